uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter: the transmit-side counterpart of the `rec` receiver. Accepts bytes through a single-clock write port into an internal FIFO and serialises them on `TXD` as 8N1 frames, LSB first. Contains its own baud counter, so no external `clkout`/`WR` strobe is needed. Sits between the send-side RAM/controller logic and the `TXD` pin.

## Interface
- `CLKS_PER_BIT`, default 5000: clocks per bit period (48 MHz / 9600 baud); legal range 2..65535.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW = 16 entries.
- `clk  in  1`: system clock; all logic is on the rising edge.
- `rst_n  in  1`: asynchronous active-low reset.
- `wr_data  in  8`: byte to enqueue.
- `wr_en  in  1`: enqueue request, sampled on the rising edge of `clk`.
- `full  out  1`: FIFO holds 2^FIFO_AW bytes.
- `empty  out  1`: FIFO holds 0 bytes.
- `count  out  FIFO_AW+1`: current FIFO occupancy, 0..2^FIFO_AW.
- `overflow  out  1`: one-cycle pulse when `wr_en` is asserted while `full`.
- `TXD  out  1`: serial output; idle level is high.
- `busy  out  1`: high from start-bit entry until the end of the stop bit.
- `tx_done  out  1`: one-cycle pulse on the last cycle of each stop bit.

## Operation
- Reset values: `TXD`=1, `busy`=0, `tx_done`=0, `overflow`=0, `full`=0, `empty`=1, `count`=0. The FIFO pointers clear and the FSM returns to IDLE. Reset takes effect immediately, including mid-frame; the partial frame is abandoned.
- FIFO is a circular buffer with FIFO_AW-bit read and write pointers that wrap from 2^FIFO_AW-1 to 0, plus a `count` register.
- Write rules:
  - `wr_en` && !`full`: store the byte and increment `count`.
  - `wr_en` && `full`: drop the byte, leave pointers unchanged, pulse `overflow`.
  - `full` is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs on the same edge.
- Simultaneous write (not full) and pop: both take effect and `count` is unchanged.
- FSM states, all outputs registered:
  - IDLE: `TXD`=1. If !`empty`, pop the head byte into an 8-bit shift register, then go to START.
  - START: `TXD`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `TXD`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: `TXD`=1 for CLKS_PER_BIT cycles. On the last cycle, pulse `tx_done`. If the FIFO is non-empty at that edge, pop and go directly to START (no idle gap); otherwise go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1. It resets to 0 on every state or bit change and is held at 0 in IDLE.
- `busy` = (state != IDLE).
- A frame is 10 bit periods: 1 start, 8 data, 1 stop.

## Timing
- Write into an empty idle block at edge N:
  - `empty` goes low after edge N.
  - The FSM pops at edge N+1.
  - `TXD` falls and `busy` rises after edge N+1. Latency is 2 clocks from the `wr_en` sample.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the `TXD` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins the cycle after the `tx_done` pulse.
- The pop decrements `count` on the same edge on which START is entered.
- `overflow` and `tx_done` are high for exactly one cycle.

## Test plan
- Reset/idle, CLKS_PER_BIT=4: hold `rst_n`=0, then release. Required: `TXD`=1, `empty`=1, `count`=0, `busy`=0 for 100 cycles.
- Single byte 0xA5 written at edge N. Required:
  - `TXD` falls after edge N+1.
  - Sampled every 4 cycles, `TXD` reads 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses at cycle N+41.
  - `busy` drops after that edge.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive edges. Required:
  - `count` peaks at 2.
  - Three frames are transmitted with no idle cycles between stop bit and next start bit.
  - Total `busy` duration is 120 cycles.
- Full/overflow, FIFO_AW=2 (4 entries):
  - Write 6 bytes on consecutive edges while the first frame starts.
  - Required: `full` asserts, exactly one `overflow` pulse occurs for the 6th write, and exactly 5 bytes are transmitted in order.
- Simultaneous write and pop: write on the same edge the FSM pops at the stop-bit end. Required: `count` is unchanged and the byte order is preserved.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3. Required:
  - `TXD`=1 and `busy`=0 immediately, without waiting for a clock.
  - After release, `empty`=1 and no residual frame is sent.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Write-port, FIFO status and serial-line bundle for uart_tx_fifo.
// The producer uses the master view; the transmitter uses the slave view.
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       wr_data;
    logic             wr_en;
    logic             full;
    logic             empty;
    logic [FIFO_AW:0] count;
    logic             overflow;
    logic             TXD;
    logic             busy;
    logic             tx_done;

    modport master (
        output wr_data, wr_en,
        input  full, empty, count, overflow, TXD, busy, tx_done
    );

    modport slave (
        input  wr_data, wr_en,
        output full, empty, count, overflow, TXD, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular-buffer FIFO feeding a
// start/data/stop serialiser with its own baud counter, LSB first.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5000,
    parameter int FIFO_AW      = 4
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0]        BAUD_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]        BAUD_PRE_LAST = 16'(CLKS_PER_BIT - 2);
    localparam logic [FIFO_AW:0]   FULL_COUNT    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE       = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE       = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count_q;
    logic               ovf_q;

    state_t      state;
    logic [15:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        txd_q;
    logic        busy_q;
    logic        done_q;

    logic full_w;
    logic empty_w;
    logic baud_end;
    logic push;
    logic pop;

    // Full is judged on the registered occupancy, so a write that meets a
    // full FIFO is dropped even when the serialiser pops on the same edge.
    assign full_w   = (count_q == FULL_COUNT);
    assign empty_w  = (count_q == '0);
    assign baud_end = (baud == BAUD_LAST);
    assign push     = bus.wr_en && !full_w;
    assign pop      = !empty_w && ((state == IDLE) || (state == STOP && baud_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= bus.wr_en && full_w;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // NOTE: every state register here uses <=, so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    baud   <= '0;
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        state  <= START;
                        txd_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        txd_q   <= shift[0];
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txd_q   <= shift[1];
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                STOP: begin
                    // Registered pulse lands on the final cycle of the stop bit.
                    if (baud == BAUD_PRE_LAST) done_q <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            txd_q <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.TXD      = txd_q;
    assign bus.busy     = busy_q;
    assign bus.tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a 16-entry and a 4-entry instance at 4
// clocks per bit, with a serial-line decoder checking bytes against a queue.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_AW(4)) bus_a ();
    uart_tx_fifo_if #(.FIFO_AW(2)) bus_b ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a.slave)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int frames_a = 0;
    int frames_b = 0;
    int ovf_b    = 0;

    int peak_cnt, busy_cyc, busy_falls, dones;
    logic prev_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sample_a();
        if (int'(bus_a.count) > peak_cnt) peak_cnt = int'(bus_a.count);
        if (bus_a.busy === 1'b1) busy_cyc++;
        if (prev_busy === 1'b1 && bus_a.busy === 1'b0) busy_falls++;
        if (bus_a.tx_done === 1'b1) dones++;
        prev_busy = bus_a.busy;
    endtask

    // Serial decoder for instance a: samples mid-bit, pops the scoreboard per frame.
    int         rx_cnt_a = 0;
    bit         rx_on_a  = 1'b0;
    logic [7:0] rx_a     = '0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_on_a  = 1'b0;
            rx_cnt_a = 0;
        end else if (!rx_on_a) begin
            if (bus_a.TXD === 1'b0) begin
                rx_on_a  = 1'b1;
                rx_cnt_a = 0;
            end
        end else begin
            rx_cnt_a++;
            if (rx_cnt_a == CPB / 2) begin
                check("start_bit_a", bus_a.TXD, 1'b0);
            end else if (rx_cnt_a < 9 * CPB && rx_cnt_a % CPB == CPB / 2) begin
                rx_a = {bus_a.TXD, rx_a[7:1]};
            end else if (rx_cnt_a == 9 * CPB + CPB / 2) begin
                rx_on_a = 1'b0;
                frames_a++;
                check("stop_bit_a", bus_a.TXD, 1'b1);
                if (q_a.size() > 0) check("frame_a", rx_a, q_a.pop_front());
                else check("unexpected_frame_a", q_a.size(), 1);
            end
        end
    end

    int         rx_cnt_b = 0;
    bit         rx_on_b  = 1'b0;
    logic [7:0] rx_b     = '0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_on_b  = 1'b0;
            rx_cnt_b = 0;
        end else begin
            if (bus_b.overflow === 1'b1) ovf_b++;
            if (!rx_on_b) begin
                if (bus_b.TXD === 1'b0) begin
                    rx_on_b  = 1'b1;
                    rx_cnt_b = 0;
                end
            end else begin
                rx_cnt_b++;
                if (rx_cnt_b == CPB / 2) begin
                    check("start_bit_b", bus_b.TXD, 1'b0);
                end else if (rx_cnt_b < 9 * CPB && rx_cnt_b % CPB == CPB / 2) begin
                    rx_b = {bus_b.TXD, rx_b[7:1]};
                end else if (rx_cnt_b == 9 * CPB + CPB / 2) begin
                    rx_on_b = 1'b0;
                    frames_b++;
                    check("stop_bit_b", bus_b.TXD, 1'b1);
                    if (q_b.size() > 0) check("frame_b", rx_b, q_b.pop_front());
                    else check("unexpected_frame_b", q_b.size(), 1);
                end
            end
        end
    end

    initial begin
        logic [7:0] byte_v;
        logic       exp_bit;
        int         f0;
        int         bad;

        bus_a.wr_en = 1'b0; bus_a.wr_data = '0;
        bus_b.wr_en = 1'b0; bus_b.wr_data = '0;

        // Reset values while reset is held
        nclk(3);
        check("rst_txd",      bus_a.TXD, 1'b1);
        check("rst_busy",     bus_a.busy, 1'b0);
        check("rst_tx_done",  bus_a.tx_done, 1'b0);
        check("rst_overflow", bus_a.overflow, 1'b0);
        check("rst_full",     bus_a.full, 1'b0);
        check("rst_empty",    bus_a.empty, 1'b1);
        check("rst_count",    bus_a.count, 0);
        check("rst_empty_b",  bus_b.empty, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            nclk(1);
            check("idle_a", {bus_a.TXD, bus_a.empty, bus_a.busy, bus_a.count}, {1'b1, 1'b1, 1'b0, 5'd0});
        end

        // Single byte 0xA5
        byte_v = 8'hA5;
        bus_a.wr_data = byte_v; bus_a.wr_en = 1'b1; q_a.push_back(byte_v);
        nclk(1);
        bus_a.wr_en = 1'b0;
        check("empty_after_write", bus_a.empty, 1'b0);
        check("count_after_write", bus_a.count, 1);
        check("txd_before_pop",    bus_a.TXD, 1'b1);
        check("busy_before_pop",   bus_a.busy, 1'b0);
        nclk(1);
        check("txd_start",       bus_a.TXD, 1'b0);
        check("busy_start",      bus_a.busy, 1'b1);
        check("count_after_pop", bus_a.count, 0);
        for (int i = 1; i < 10; i++) begin
            nclk(CPB);
            exp_bit = (i == 9) ? 1'b1 : byte_v[i-1];
            check("bit_a5", bus_a.TXD, exp_bit);
        end
        for (int k = 38; k <= 41; k++) begin
            nclk(1);
            check("tx_done_a5", bus_a.tx_done, (k == 40));
            check("busy_a5",    bus_a.busy, (k <= 40));
        end
        nclk(5);
        check("a5_frames",  frames_a, 1);
        check("a5_drained", q_a.size(), 0);

        // Back-to-back 0x00, 0xFF, 0x55
        f0 = frames_a;
        peak_cnt = 0; busy_cyc = 0; busy_falls = 0; dones = 0; prev_busy = 1'b0;
        bus_a.wr_en = 1'b1;
        bus_a.wr_data = 8'h00; q_a.push_back(8'h00); nclk(1); sample_a();
        bus_a.wr_data = 8'hFF; q_a.push_back(8'hFF); nclk(1); sample_a();
        bus_a.wr_data = 8'h55; q_a.push_back(8'h55); nclk(1); sample_a();
        bus_a.wr_en = 1'b0;
        repeat (150) begin
            nclk(1);
            sample_a();
        end
        check("b2b_peak_count", peak_cnt, 2);
        check("b2b_busy_cycles", busy_cyc, 120);
        check("b2b_busy_falls", busy_falls, 1);
        check("b2b_tx_done_pulses", dones, 3);
        check("b2b_frames", frames_a - f0, 3);
        check("b2b_drained", q_a.size(), 0);

        // Write on the same edge the serialiser pops at the stop-bit end
        f0 = frames_a;
        bus_a.wr_en = 1'b1;
        bus_a.wr_data = 8'h3C; q_a.push_back(8'h3C); nclk(1);
        bus_a.wr_data = 8'hC3; q_a.push_back(8'hC3); nclk(1);
        bus_a.wr_en = 1'b0;
        nclk(39);
        check("simul_tx_done", bus_a.tx_done, 1'b1);
        check("simul_count_before", bus_a.count, 1);
        bus_a.wr_data = 8'h96; bus_a.wr_en = 1'b1; q_a.push_back(8'h96);
        nclk(1);
        bus_a.wr_en = 1'b0;
        check("simul_count_after", bus_a.count, 1);
        check("simul_next_start", bus_a.TXD, 1'b0);
        check("simul_busy", bus_a.busy, 1'b1);
        nclk(90);
        check("simul_frames", frames_a - f0, 3);
        check("simul_drained", q_a.size(), 0);

        // Overflow on the 4-entry instance
        for (int i = 0; i < 6; i++) begin
            bus_b.wr_data = 8'(8'h10 + i);
            bus_b.wr_en   = 1'b1;
            if (i < 5) q_b.push_back(8'(8'h10 + i));
            nclk(1);
            check("full_b", bus_b.full, (i >= 4));
            check("overflow_b", bus_b.overflow, (i == 5));
        end
        bus_b.wr_en = 1'b0;
        check("count_b_full", bus_b.count, 4);
        nclk(1);
        check("overflow_b_single", bus_b.overflow, 1'b0);
        nclk(210);
        check("ovf_pulses_b", ovf_b, 1);
        check("frames_b", frames_b, 5);
        check("drained_b", q_b.size(), 0);
        check("empty_b_end", bus_b.empty, 1'b1);

        // Reset during data bit 3
        f0 = frames_a;
        byte_v = 8'h6B;
        bus_a.wr_en = 1'b1;
        bus_a.wr_data = byte_v; q_a.push_back(byte_v); nclk(1);
        bus_a.wr_data = 8'h11;  q_a.push_back(8'h11);  nclk(1);
        bus_a.wr_en = 1'b0;
        nclk(17);
        check("bit3_before_reset", bus_a.TXD, byte_v[3]);
        check("busy_before_reset", bus_a.busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_txd",   bus_a.TXD, 1'b1);
        check("rst_mid_busy",  bus_a.busy, 1'b0);
        check("rst_mid_empty", bus_a.empty, 1'b1);
        check("rst_mid_count", bus_a.count, 0);
        q_a.delete();
        nclk(3);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            nclk(1);
            if (bus_a.TXD !== 1'b1 || bus_a.busy !== 1'b0) bad++;
        end
        check("no_residual_activity", bad, 0);
        check("empty_after_release", bus_a.empty, 1'b1);
        check("no_residual_frame", frames_a - f0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
